// File: rtl/instr_encode_loader_if.sv
// Bundles the burst-control, field-tuple and instruction-memory write signals of
// instr_encode_loader. The host side drives fields; the loader side drives the memory port.
interface instr_encode_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              in_valid;
    logic              in_ready;
    logic              fmt;
    logic [2:0]        opcode;
    logic [1:0]        op;
    logic [2:0]        Rn;
    logic [2:0]        Rd;
    logic [1:0]        sh;
    logic [2:0]        Rm;
    logic [7:0]        imm8;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   written;

    modport master (
        output start, base_addr, count, in_valid, fmt, opcode, op, Rn, Rd, sh, Rm, imm8,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, written
    );

    modport slave (
        input  start, base_addr, count, in_valid, fmt, opcode, op, Rn, Rd, sh, Rm, imm8,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, written
    );
endinterface

// File: rtl/instr_encode_loader.sv
// Encodes streamed field tuples into 16-bit instructions and writes them to
// consecutive instruction-memory addresses, one write per accepted tuple.
module instr_encode_loader #(
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instr_encode_loader_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       mem_wdata_q;
    logic [ADDR_W:0]   written_q;
    logic [15:0]       encoded;

    assign encoded = {bus.opcode, bus.op, bus.Rn,
                      bus.fmt ? bus.imm8 : {bus.Rd, bus.sh, bus.Rm}};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets its default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (bus.start) next_state = (bus.count != '0) ? ACCEPT : DONE;
            ACCEPT:  if (bus.in_valid) next_state = WRITE;
            WRITE:   next_state = (remaining == (ADDR_W+1)'(1)) ? DONE : ACCEPT;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            remaining   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            written_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        ptr       <= bus.base_addr;
                        remaining <= bus.count;
                        written_q <= '0;
                    end
                end
                ACCEPT: begin
                    // Address is latched with the word so mem_addr holds steady outside WRITE.
                    if (bus.in_valid) begin
                        mem_wdata_q <= encoded;
                        mem_addr_q  <= ptr;
                    end
                end
                WRITE: begin
                    ptr       <= ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    written_q <= written_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == ACCEPT);
    assign bus.mem_we    = (state == WRITE);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.written   = written_q;
endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: table of single-word encode bursts plus
// hand-written back-pressure, wrap, zero-count, start-while-busy, reset and full-range bursts.
module tb_instr_encode_loader;
    localparam int ADDR_W = 8;

    typedef struct {
        logic [7:0]  base;
        logic        fmt;
        logic [2:0]  opcode;
        logic [1:0]  op;
        logic [2:0]  rn;
        logic [2:0]  rd;
        logic [1:0]  sh;
        logic [2:0]  rm;
        logic [7:0]  imm8;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   ready_in_write = 0;
    wr_t  cap[$];

    instr_encode_loader_if #(.ADDR_W(ADDR_W)) bus ();
    instr_encode_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we) cap.push_back('{addr: bus.mem_addr, data: bus.mem_wdata});
        if (bus.mem_we && bus.in_ready) ready_in_write++;
        if (bus.done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] base, input logic [8:0] cnt);
        bus.start = 1'b1;
        bus.base_addr = base;
        bus.count = cnt;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send(input vec_t v, input int gap);
        bit ok = 0;
        bus.in_valid = 1'b0;
        repeat (gap) step();
        bus.fmt = v.fmt; bus.opcode = v.opcode; bus.op = v.op; bus.Rn = v.rn;
        bus.Rd = v.rd;   bus.sh = v.sh;         bus.Rm = v.rm; bus.imm8 = v.imm8;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready) begin
                step();
                ok = 1;
                break;
            end
            step();
        end
        bus.in_valid = 1'b0;
        if (!ok) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int max_cycles);
        bit ok = 0;
        for (int i = 0; i < max_cycles; i++) begin
            if (bus.done) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) check("done_timeout", 32'd0, 32'd1);
    endtask

    function automatic vec_t mk(input logic [2:0] opcode, input logic [1:0] op, input logic [2:0] rn,
                                input logic fmt, input logic [7:0] imm8);
        vec_t v;
        v = '{base: 8'h00, fmt: fmt, opcode: opcode, op: op, rn: rn, rd: imm8[7:5], sh: imm8[4:3],
              rm: imm8[2:0], imm8: imm8, exp: 16'h0000};
        return v;
    endfunction

    vec_t vecs[6];
    vec_t t;
    int   d0;
    int   hits[256];
    int   bad;

    initial begin
        vecs[0] = '{8'h10, 1'b1, 3'b110, 2'b10, 3'b001, 3'b000, 2'b00, 3'b000, 8'h05, 16'hD105};
        vecs[1] = '{8'h11, 1'b0, 3'b101, 2'b00, 3'b001, 3'b010, 2'b01, 3'b000, 8'hFF, 16'hA148};
        vecs[2] = '{8'hFF, 1'b1, 3'b000, 2'b00, 3'b000, 3'b111, 2'b11, 3'b111, 8'hFF, 16'h00FF};
        vecs[3] = '{8'h80, 1'b0, 3'b111, 2'b11, 3'b111, 3'b111, 2'b11, 3'b111, 8'h00, 16'hFFFF};
        vecs[4] = '{8'h3C, 1'b0, 3'b011, 2'b01, 3'b110, 3'b100, 2'b10, 3'b011, 8'h00, 16'h6E93};
        vecs[5] = '{8'h00, 1'b1, 3'b010, 2'b10, 3'b101, 3'b001, 2'b01, 3'b110, 8'hA5, 16'h55A5};

        bus.start = 0; bus.base_addr = '0; bus.count = '0; bus.in_valid = 0;
        bus.fmt = 0; bus.opcode = '0; bus.op = '0; bus.Rn = '0; bus.Rd = '0;
        bus.sh = '0; bus.Rm = '0; bus.imm8 = '0;

        // Reset state
        #12;
        check("rst_outputs", 32'({bus.in_ready, bus.mem_we, bus.busy, bus.done}), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_written", 32'(bus.written), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        step();

        // Single-word encode bursts from the table
        foreach (vecs[k]) begin
            cap.delete();
            d0 = done_cnt;
            do_start(vecs[k].base, 9'd1);
            check($sformatf("v%0d_ready_busy", k), 32'({bus.in_ready, bus.busy}), 32'd3);
            send(vecs[k], 0);
            check($sformatf("v%0d_we", k), 32'({bus.mem_we, bus.in_ready}), 32'd2);
            check($sformatf("v%0d_addr", k), 32'(bus.mem_addr), 32'(vecs[k].base));
            check($sformatf("v%0d_data", k), 32'(bus.mem_wdata), 32'(vecs[k].exp));
            step();
            check($sformatf("v%0d_done", k), 32'({bus.done, bus.busy, bus.mem_we}), 32'd6);
            check($sformatf("v%0d_written", k), 32'(bus.written), 32'd1);
            step();
            check($sformatf("v%0d_idle", k), 32'({bus.busy, bus.done}), 32'd0);
            check($sformatf("v%0d_nwrites", k), 32'(cap.size()), 32'd1);
            check($sformatf("v%0d_ndone", k), 32'(done_cnt - d0), 32'd1);
        end

        // Back-pressure burst: tuples 0x1111, 0x2222-ish patterns with valid gaps
        cap.delete();
        do_start(8'h00, 9'd3);
        send(mk(3'b001, 2'b01, 3'b010, 1'b1, 8'h11), 0);
        send(mk(3'b010, 2'b10, 3'b011, 1'b1, 8'h22), 2);
        send(mk(3'b011, 2'b11, 3'b100, 1'b1, 8'h33), 0);
        wait_done(10);
        check("bp_written", 32'(bus.written), 32'd3);
        step();
        check("bp_nwrites", 32'(cap.size()), 32'd3);
        if (cap.size() == 3) begin
            check("bp_w0", 32'({cap[0].addr, cap[0].data}), 32'h00_2A11);
            check("bp_w1", 32'({cap[1].addr, cap[1].data}), 32'h01_5322);
            check("bp_w2", 32'({cap[2].addr, cap[2].data}), 32'h02_7C33);
        end
        check("ready_low_in_write", 32'(ready_in_write), 32'd0);

        // Address wrap
        cap.delete();
        do_start(8'hFE, 9'd3);
        for (int i = 0; i < 3; i++) send(mk(3'b000, 2'b00, 3'b000, 1'b1, 8'(i)), 0);
        wait_done(10);
        step();
        check("wrap_nwrites", 32'(cap.size()), 32'd3);
        if (cap.size() == 3)
            check("wrap_addrs", 32'({cap[0].addr, cap[1].addr, cap[2].addr}), 32'hFEFF00);

        // Zero-count burst
        cap.delete();
        d0 = done_cnt;
        do_start(8'h55, 9'd0);
        check("zero_done", 32'({bus.done, bus.mem_we, bus.in_ready}), 32'd4);
        check("zero_written", 32'(bus.written), 32'd0);
        step();
        check("zero_idle", 32'({bus.busy, bus.done}), 32'd0);
        step();
        check("zero_nwrites", 32'(cap.size()), 32'd0);
        check("zero_ndone", 32'(done_cnt - d0), 32'd1);

        // Start while busy is ignored
        cap.delete();
        do_start(8'h20, 9'd3);
        send(mk(3'b100, 2'b00, 3'b000, 1'b1, 8'hA0), 0);
        bus.start = 1'b1; bus.base_addr = 8'h40; bus.count = 9'd5;
        send(mk(3'b100, 2'b00, 3'b000, 1'b1, 8'hA1), 1);
        send(mk(3'b100, 2'b00, 3'b000, 1'b1, 8'hA2), 0);
        bus.start = 1'b0;
        wait_done(10);
        check("sb_written", 32'(bus.written), 32'd3);
        step();
        check("sb_nwrites", 32'(cap.size()), 32'd3);
        if (cap.size() == 3)
            check("sb_addrs", 32'({cap[0].addr, cap[1].addr, cap[2].addr}), 32'h202122);

        // Reset mid-burst
        cap.delete();
        d0 = done_cnt;
        do_start(8'h50, 9'd4);
        send(mk(3'b001, 2'b00, 3'b000, 1'b1, 8'h01), 0);
        step();
        check("mr_in_accept", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr_outputs", 32'({bus.in_ready, bus.mem_we, bus.busy, bus.done}), 32'd0);
        check("mr_regs", 32'({bus.mem_addr, bus.written}), 32'd0);
        check("mr_wdata", 32'(bus.mem_wdata), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();
        check("mr_no_done", 32'(done_cnt - d0), 32'd0);
        check("mr_nwrites", 32'(cap.size()), 32'd1);
        cap.delete();
        do_start(8'h60, 9'd2);
        send(mk(3'b111, 2'b00, 3'b000, 1'b0, 8'h00), 0);
        send(mk(3'b110, 2'b00, 3'b000, 1'b0, 8'h00), 0);
        wait_done(10);
        check("mr_restart_written", 32'(bus.written), 32'd2);
        step();
        check("mr_restart_nwrites", 32'(cap.size()), 32'd2);
        if (cap.size() == 2)
            check("mr_restart_w", 32'({cap[0].addr, cap[0].data, cap[1].addr}), 32'h60E000_61);

        // Full-range burst: every location written once
        cap.delete();
        do_start(8'h37, 9'd256);
        for (int i = 0; i < 256; i++) send(mk(3'b010, 2'b01, 3'b000, 1'b1, 8'(i)), 0);
        wait_done(10);
        check("full_written", 32'(bus.written), 32'd256);
        step();
        check("full_nwrites", 32'(cap.size()), 32'd256);
        foreach (hits[a]) hits[a] = 0;
        foreach (cap[j]) hits[cap[j].addr]++;
        bad = 0;
        foreach (hits[a]) if (hits[a] != 1) bad++;
        check("full_coverage", 32'(bad), 32'd0);
        if (cap.size() == 256)
            check("full_last", 32'({cap[255].addr, cap[255].data}), 32'h36_48FF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
